// File: rtl/rf_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter_if
//
// Bundles the requester-facing write handshake and the register-file write
// port of rf_write_arbiter.
//
// Handshake: requester i presents a write by raising req_valid[i] with
// req_addr/req_data stable. The write is consumed at the rising clock edge
// where req_valid[i] and req_ready[i] are both 1. req_ready may depend
// combinationally on req_valid, but req_valid must never depend on req_ready.
// A requester keeps valid, address and data unchanged until that edge.
//
// Signals:
//   hold       freeze arbitration (no grants while high)
//   req_valid  NREQ bits, one per requester
//   req_addr   NREQ*AW, requester i at [i*AW +: AW]
//   req_data   NREQ*DW, requester i at [i*DW +: DW]
//   req_ready  one-hot or zero acknowledge
//   rf_we      registered register-file write enable
//   rf_waddr   registered register-file write address
//   rf_wdata   registered register-file write data
//   grant_id   index of the requester whose write is on the port
//   dbg_ptr    current round-robin priority pointer (observability)
//
// Modports: master = requester/producer side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface rf_write_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic                 hold;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 rf_we;
    logic [AW-1:0]        rf_waddr;
    logic [DW-1:0]        rf_wdata;
    logic [IW-1:0]        grant_id;
    logic [IW-1:0]        dbg_ptr;

    modport master (
        output hold,
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready,
        input  rf_we,
        input  rf_waddr,
        input  rf_wdata,
        input  grant_id,
        input  dbg_ptr
    );

    modport slave (
        input  hold,
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready,
        output rf_we,
        output rf_waddr,
        output rf_wdata,
        output grant_id,
        output dbg_ptr
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
//
// Round-robin arbiter sharing the register file's single write port among
// NREQ result producers. At most one write is accepted per cycle. The winning
// address/data are captured into an output register that drives the
// register-file write port; the register file itself captures on the falling
// edge, so a write granted at rising edge k lands half a cycle later.
//
// Parameters:
//   NREQ      number of requesters (2..8)
//   AW        register address width
//   DW        register data width
//   ZERO_REG  when 1, writes to address 0 are acknowledged but rf_we stays 0
//
// Ports:
//   clk       clock, state updates on the rising edge
//   reset     asynchronous, active-high reset
//   bus       rf_write_arbiter_if slave modport (handshake + write port)
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
    parameter int NREQ     = 3,
    parameter int AW       = 5,
    parameter int DW       = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    rf_write_arbiter_if.slave    bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    generate
        if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
            $error("rf_write_arbiter: NREQ must be in 2..8");
        end
    endgenerate

    // Priority pointer: the index scanned first in the next arbitration.
    logic [IW-1:0] ptr;

    // Combinational arbitration results.
    logic          found;
    logic [IW-1:0] winner;
    logic          grant;
    logic [IW:0]   scan_sum;
    logic [IW-1:0] scan_idx;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_data;
    logic          win_we;
    logic [IW-1:0] ptr_next;

    // Scan ptr, ptr+1, ... modulo NREQ and pick the first valid requester.
    // The modulo is an explicit compare-and-subtract so that a
    // non-power-of-two NREQ never produces an out-of-range index.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int j = 0; j < NREQ; j++) begin
            scan_sum = {1'b0, ptr} + (IW+1)'(j);
            if (scan_sum >= (IW+1)'(NREQ)) begin
                scan_sum = scan_sum - (IW+1)'(NREQ);
            end
            scan_idx = scan_sum[IW-1:0];
            if (!found && bus.req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    // hold and reset both suppress the acknowledge in the same cycle.
    assign grant = found && !bus.hold && !reset;

    always_comb begin
        bus.req_ready = '0;
        if (grant) begin
            bus.req_ready[winner] = 1'b1;
        end
    end

    assign win_addr = bus.req_addr[winner*AW +: AW];
    assign win_data = bus.req_data[winner*DW +: DW];

    // A suppressed address-0 write is still a grant; only the enable drops.
    assign win_we = !(ZERO_REG && (win_addr == '0));

    // Pointer moves to the slot after the winner, wrapping explicitly.
    assign ptr_next = (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;

    // Output register and pointer. Reset clears the output register at once
    // so a pending write is dropped before the register file's falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr          <= '0;
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
            bus.grant_id <= '0;
        end else if (grant) begin
            ptr          <= ptr_next;
            bus.rf_we    <= win_we;
            bus.rf_waddr <= win_addr;
            bus.rf_wdata <= win_data;
            bus.grant_id <= winner;
        end else begin
            // Idle or held: only the enable drops; the rest keeps its value.
            bus.rf_we    <= 1'b0;
        end
    end

    assign bus.dbg_ptr = ptr;

endmodule
